elevator_dispatcher: RTL and testbench

- Hall-call scheduler for the two-car elevator system.
- Collects floor calls into a pending bitmap and picks one call at a time in round-robin order.
- Assigns each call to the nearest eligible car and issues it over a valid/ack handshake to that car's controller.
- Counts dispatches per car as turnover.

---
 rtl/elevator_pkg.sv | 16 +
 rtl/rr_floor_picker.sv | 26 ++
 rtl/elevator_dispatcher.sv | 170 +++++++++++++++++
 tb/tb_elevator_dispatcher.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared constants and types for the hall-call dispatcher.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 8;
  localparam int unsigned FLOOR_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PICK  = 2'd1,
    ISSUE = 2'd2
  } disp_state_e;

  localparam logic CAR1 = 1'b0;
  localparam logic CAR2 = 1'b1;

endpackage

// File: rtl/rr_floor_picker.sv
// Round-robin search of the pending bitmap starting at rr_ptr, wrapping at the top floor.
module rr_floor_picker
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    rr_ptr,
  output logic [FLOOR_W-1:0]    target,
  output logic                  found
);

  // First set bit at or above rr_ptr, modulo NUM_FLOORS.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    target = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_FLOORS;
      if (!found && pending[idx]) begin
        found  = 1'b1;
        target = FLOOR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/elevator_dispatcher.sv
// Two-car hall-call dispatcher: captures calls, picks one round-robin, hands it to the
// nearest eligible car over valid/ack and counts accepted dispatches per car.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic [FLOOR_W-1:0]    car1_floor,
  input  logic [FLOOR_W-1:0]    car2_floor,
  input  logic                  car1_busy,
  input  logic                  car2_busy,
  input  logic                  car1_complete,
  input  logic                  car2_complete,
  input  logic                  car1_over_weight,
  input  logic                  car2_over_weight,
  output logic                  car1_req_valid,
  output logic [FLOOR_W-1:0]    car1_req_floor,
  input  logic                  car1_req_ack,
  output logic                  car2_req_valid,
  output logic [FLOOR_W-1:0]    car2_req_floor,
  input  logic                  car2_req_ack,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [CNT_W-1:0]      turnover1,
  output logic [CNT_W-1:0]      turnover2
);

  disp_state_e           state;
  logic [FLOOR_W-1:0]    target;
  logic [FLOOR_W-1:0]    rr_ptr;
  logic                  car_sel;
  logic                  assigned1;
  logic                  assigned2;

  logic                  elig1;
  logic                  elig2;
  logic [FLOOR_W-1:0]    pick_floor;
  logic                  pick_found;
  logic [FLOOR_W:0]      d1;
  logic [FLOOR_W:0]      d2;
  logic                  pick_car;
  logic                  pick_ok;
  logic                  acc1;
  logic                  acc2;
  logic                  abort;
  logic [NUM_FLOORS-1:0] call_set;
  logic [NUM_FLOORS-1:0] call_clr;
  logic [FLOOR_W-1:0]    rr_next;

  rr_floor_picker u_picker (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .target  (pick_floor),
    .found   (pick_found)
  );

  // Eligibility, distance-based car choice, handshake decode and pending set/clear masks.
  always_comb begin
    elig1 = !car1_busy && !assigned1 && !car1_over_weight;
    elig2 = !car2_busy && !assigned2 && !car2_over_weight;

    d1 = (car1_floor >= pick_floor) ? ({1'b0, car1_floor} - {1'b0, pick_floor})
                                    : ({1'b0, pick_floor} - {1'b0, car1_floor});
    d2 = (car2_floor >= pick_floor) ? ({1'b0, car2_floor} - {1'b0, pick_floor})
                                    : ({1'b0, pick_floor} - {1'b0, car2_floor});

    // Ties go to car 1; a car that lost eligibility since IDLE is simply never chosen.
    pick_car = (elig1 && (!elig2 || d1 <= d2)) ? CAR1 : CAR2;
    pick_ok  = pick_found && (elig1 || elig2);

    acc1  = (state == ISSUE) && car1_req_valid && car1_req_ack;
    acc2  = (state == ISSUE) && car2_req_valid && car2_req_ack;
    abort = (state == ISSUE) &&
            (((car_sel == CAR1) && car1_over_weight) || ((car_sel == CAR2) && car2_over_weight));

    call_set = '0;
    if (call_valid && ({1'b0, call_floor} < (FLOOR_W+1)'(NUM_FLOORS))) begin
      call_set[call_floor] = 1'b1;
    end

    call_clr = '0;
    if (acc1 || acc2) begin
      call_clr[target] = 1'b1;
    end

    rr_next = (target == FLOOR_W'(NUM_FLOORS - 1)) ? '0 : target + 1'b1;
  end

  // Dispatch FSM with registered request outputs, pending bitmap, assignment flags and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      target         <= '0;
      rr_ptr         <= '0;
      car_sel        <= CAR1;
      assigned1      <= 1'b0;
      assigned2      <= 1'b0;
      pending        <= '0;
      car1_req_valid <= 1'b0;
      car1_req_floor <= '0;
      car2_req_valid <= 1'b0;
      car2_req_floor <= '0;
      turnover1      <= '0;
      turnover2      <= '0;
    end else begin
      // A new call to the floor being cleared wins over the clear.
      pending <= (pending & ~call_clr) | call_set;

      // Acceptance wins over a simultaneous complete pulse.
      if (acc1) begin
        assigned1 <= 1'b1;
        turnover1 <= turnover1 + CNT_W'(1);
      end else if (car1_complete) begin
        assigned1 <= 1'b0;
      end

      if (acc2) begin
        assigned2 <= 1'b1;
        turnover2 <= turnover2 + CNT_W'(1);
      end else if (car2_complete) begin
        assigned2 <= 1'b0;
      end

      case (state)
        IDLE: begin
          if ((pending != '0) && (elig1 || elig2)) begin
            state <= PICK;
          end
        end
        PICK: begin
          if (pick_ok) begin
            target  <= pick_floor;
            car_sel <= pick_car;
            if (pick_car == CAR1) begin
              car1_req_valid <= 1'b1;
              car1_req_floor <= pick_floor;
            end else begin
              car2_req_valid <= 1'b1;
              car2_req_floor <= pick_floor;
            end
            state <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (acc1 || acc2) begin
            car1_req_valid <= 1'b0;
            car2_req_valid <= 1'b0;
            rr_ptr         <= rr_next;
            state          <= IDLE;
          end else if (abort) begin
            car1_req_valid <= 1'b0;
            car2_req_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: begin
          car1_req_valid <= 1'b0;
          car2_req_valid <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed bench for elevator_dispatcher with hand-computed expectations.
module tb_elevator_dispatcher;
  import elevator_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  call_valid;
  logic [FLOOR_W-1:0]    call_floor;
  logic [FLOOR_W-1:0]    car1_floor;
  logic [FLOOR_W-1:0]    car2_floor;
  logic                  car1_busy;
  logic                  car2_busy;
  logic                  car1_complete;
  logic                  car2_complete;
  logic                  car1_over_weight;
  logic                  car2_over_weight;
  logic                  car1_req_valid;
  logic [FLOOR_W-1:0]    car1_req_floor;
  logic                  car1_req_ack;
  logic                  car2_req_valid;
  logic [FLOOR_W-1:0]    car2_req_floor;
  logic                  car2_req_ack;
  logic [NUM_FLOORS-1:0] pending;
  logic [7:0]            turnover1;
  logic [7:0]            turnover2;

  int total = 0;
  int bad   = 0;

  elevator_dispatcher #(.CNT_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .call_valid       (call_valid),
    .call_floor       (call_floor),
    .car1_floor       (car1_floor),
    .car2_floor       (car2_floor),
    .car1_busy        (car1_busy),
    .car2_busy        (car2_busy),
    .car1_complete    (car1_complete),
    .car2_complete    (car2_complete),
    .car1_over_weight (car1_over_weight),
    .car2_over_weight (car2_over_weight),
    .car1_req_valid   (car1_req_valid),
    .car1_req_floor   (car1_req_floor),
    .car1_req_ack     (car1_req_ack),
    .car2_req_valid   (car2_req_valid),
    .car2_req_floor   (car2_req_floor),
    .car2_req_ack     (car2_req_ack),
    .pending          (pending),
    .turnover1        (turnover1),
    .turnover2        (turnover2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_v1(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (car1_req_valid) seen = 1'b1;
      else step();
    end
  endtask

  task automatic call(input int f);
    call_valid = 1'b1;
    call_floor = FLOOR_W'(f);
    step();
    call_valid = 1'b0;
  endtask

  // Wait for a car 1 request, check its floor, ack it and optionally pulse complete.
  task automatic serve1(input string tag, input int exp_floor, input bit do_complete);
    bit seen;
    wait_v1(seen);
    check({tag, "_valid"}, 32'(seen), 32'd1);
    check({tag, "_floor"}, 32'(car1_req_floor), 32'(exp_floor));
    car1_req_ack = 1'b1;
    step();
    car1_req_ack = 1'b0;
    if (do_complete) begin
      car1_complete = 1'b1;
      step();
      car1_complete = 1'b0;
    end
  endtask

  initial begin
    bit seen;
    int misses;
    int rr_exp[3] = '{1, 3, 6};

    rst = 1'b1;
    call_valid = 1'b0; call_floor = '0;
    car1_floor = '0; car2_floor = 3'd7;
    car1_busy = 1'b0; car2_busy = 1'b0;
    car1_complete = 1'b0; car2_complete = 1'b0;
    car1_over_weight = 1'b0; car2_over_weight = 1'b0;
    car1_req_ack = 1'b0; car2_req_ack = 1'b0;

    step();
    step();
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_v1", 32'(car1_req_valid), 32'd0);
    check("rst_v2", 32'(car2_req_valid), 32'd0);
    check("rst_t1", 32'(turnover1), 32'd0);
    check("rst_t2", 32'(turnover2), 32'd0);
    rst = 1'b0;

    // Basic dispatch: cars at 0 and 7, call 2 -> car 1 two edges after capture.
    call(2);
    check("basic_pend", 32'(pending), 32'h04);
    check("basic_v1_early", 32'(car1_req_valid), 32'd0);
    step();
    check("basic_v1_pick", 32'(car1_req_valid), 32'd0);
    step();
    check("basic_v1", 32'(car1_req_valid), 32'd1);
    check("basic_f1", 32'(car1_req_floor), 32'd2);
    check("basic_v2", 32'(car2_req_valid), 32'd0);
    car1_req_ack = 1'b1;
    step();
    car1_req_ack = 1'b0;
    check("basic_v1_drop", 32'(car1_req_valid), 32'd0);
    check("basic_pend_clr", 32'(pending), 32'h0);
    check("basic_t1", 32'(turnover1), 32'd1);
    car1_complete = 1'b1; step(); car1_complete = 1'b0;

    // Nearest car: cars at 0 and 6, call 5 -> car 2.
    car1_floor = 3'd0; car2_floor = 3'd6;
    call(5);
    step(); step();
    check("near_v2", 32'(car2_req_valid), 32'd1);
    check("near_f2", 32'(car2_req_floor), 32'd5);
    check("near_v1", 32'(car1_req_valid), 32'd0);
    car2_req_ack = 1'b1; step(); car2_req_ack = 1'b0;
    check("near_t2", 32'(turnover2), 32'd1);
    car2_complete = 1'b1; step(); car2_complete = 1'b0;

    // Tie: cars at 3 and 7, call 5 -> car 1.
    car1_floor = 3'd3; car2_floor = 3'd7;
    call(5);
    step(); step();
    check("tie_v1", 32'(car1_req_valid), 32'd1);
    check("tie_f1", 32'(car1_req_floor), 32'd5);
    check("tie_v2", 32'(car2_req_valid), 32'd0);
    car1_req_ack = 1'b1; step(); car1_req_ack = 1'b0;
    car1_complete = 1'b1; step(); car1_complete = 1'b0;

    // Overweight: no eligible car, call held.
    car1_over_weight = 1'b1; car2_busy = 1'b1;
    call(4);
    for (int i = 0; i < 4; i++) step();
    check("ow_v1", 32'(car1_req_valid), 32'd0);
    check("ow_v2", 32'(car2_req_valid), 32'd0);
    check("ow_pend", 32'(pending), 32'h10);
    car2_busy = 1'b0;
    step(); step();
    check("ow_v2_go", 32'(car2_req_valid), 32'd1);
    check("ow_f2", 32'(car2_req_floor), 32'd4);
    car2_over_weight = 1'b1;
    step();
    check("ow_abort_v2", 32'(car2_req_valid), 32'd0);
    check("ow_abort_pend", 32'(pending), 32'h10);
    check("ow_abort_t2", 32'(turnover2), 32'd1);
    car1_over_weight = 1'b0; car2_over_weight = 1'b0;
    serve1("ow_retry", 4, 1'b1);
    check("ow_retry_pend", 32'(pending), 32'h0);
    check("ow_retry_t1", 32'(turnover1), 32'd3);

    // Round-robin from a fresh rr_ptr of 0.
    rst = 1'b1; step(); rst = 1'b0;
    car1_busy = 1'b1; car2_busy = 1'b1;
    call(1); call(3); call(6);
    check("rr_pend", 32'(pending), 32'h4A);
    car1_busy = 1'b0;
    for (int i = 0; i < 3; i++) serve1($sformatf("rr%0d", i), rr_exp[i], (i != 2));
    check("rr_pend_empty", 32'(pending), 32'h0);
    car1_busy = 1'b1;
    car1_complete = 1'b1; step(); car1_complete = 1'b0;
    call(2); call(0);
    car1_busy = 1'b0;
    serve1("rr_wrap", 0, 1'b1);
    check("rr_wrap_pend", 32'(pending), 32'h04);
    serve1("rr_after", 2, 1'b1);
    check("rr_t1", 32'(turnover1), 32'd5);

    // Repeat call to 3 plus complete in the ack cycle.
    call(3);
    wait_v1(seen);
    check("sim_valid", 32'(seen), 32'd1);
    check("sim_floor", 32'(car1_req_floor), 32'd3);
    car1_req_ack = 1'b1; car1_complete = 1'b1;
    call_valid = 1'b1; call_floor = 3'd3;
    step();
    car1_req_ack = 1'b0; car1_complete = 1'b0; call_valid = 1'b0;
    check("sim_v1_drop", 32'(car1_req_valid), 32'd0);
    check("sim_pend_set", 32'(pending), 32'h08);
    check("sim_t1", 32'(turnover1), 32'd6);
    for (int i = 0; i < 5; i++) step();
    check("sim_assigned_hold", 32'(car1_req_valid), 32'd0);
    car1_complete = 1'b1; step(); car1_complete = 1'b0;
    wait_v1(seen);
    check("sim_redispatch", 32'(seen), 32'd1);
    check("sim_redispatch_f", 32'(car1_req_floor), 32'd3);

    // Async reset mid-handshake.
    rst = 1'b1;
    #1;
    check("arst_v1", 32'(car1_req_valid), 32'd0);
    check("arst_pend", 32'(pending), 32'h0);
    check("arst_t1", 32'(turnover1), 32'd0);
    check("arst_t2", 32'(turnover2), 32'd0);
    step();
    rst = 1'b0;

    // 256 accepted dispatches wrap turnover1 back to 0.
    misses = 0;
    for (int i = 0; i < 256; i++) begin
      call(i % 8);
      wait_v1(seen);
      if (!seen || car1_req_floor != FLOOR_W'(i % 8)) misses++;
      car1_req_ack = 1'b1; step(); car1_req_ack = 1'b0;
      if (i == 254) check("wrap_t1_255", 32'(turnover1), 32'd255);
      car1_complete = 1'b1; step(); car1_complete = 1'b0;
    end
    check("wrap_misses", 32'(misses), 32'd0);
    check("wrap_t1_0", 32'(turnover1), 32'd0);
    check("wrap_t2", 32'(turnover2), 32'd0);
    check("wrap_pend", 32'(pending), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
